// File: rtl/stim_pkg.sv
// Shared types and helpers for the stimulus pulse scheduler.
package stim_pkg;

    localparam int TW_DEF  = 16;
    localparam int NCH_DEF = 4;

    typedef enum logic [2:0] {
        IDLE,
        REST,
        PRE,
        ANO,
        IPD,
        CAT,
        POST
    } state_e;

    // Isolate the least significant set bit (zero in, zero out).
    function automatic logic [NCH_DEF-1:0] lowest_bit(input logic [NCH_DEF-1:0] v);
        return v & (~v + NCH_DEF'(1));
    endfunction

    // Next allowed cathode strictly above ptr, wrapping to the lowest allowed bit.
    function automatic logic [NCH_DEF-1:0] next_cat(input logic [NCH_DEF-1:0] ptr,
                                                    input logic [NCH_DEF-1:0] mask);
        logic [NCH_DEF-1:0] above;
        logic               seen;
        above = '0;
        seen  = 1'b0;
        for (int i = 0; i < NCH_DEF; i++) begin
            above[i] = seen;
            if (ptr[i]) seen = 1'b1;
        end
        if ((mask & above) != '0) return lowest_bit(mask & above);
        return lowest_bit(mask);
    endfunction

endpackage

// File: rtl/stim_us_timer.sv
// Microsecond phase timer: a CLK_PER_US prescaler feeding a TW-bit down-counter.
// After a load of N, done_o is high in the last of N*CLK_PER_US cycles, so a
// state entered on the load edge and left on the done edge lasts exactly that long.
// A load of 0 behaves like a load of 1 (one microsecond).
module stim_us_timer #(
    parameter int CLK_PER_US = 10,
    parameter int TW         = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load_i,
    input  logic [TW-1:0] value_i,
    output logic          done_o
);

    localparam int            PW       = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(CLK_PER_US - 1);
    localparam logic [TW-1:0] CNT_ONE  = TW'(1);

    logic [PW-1:0] pre_q;
    logic [TW-1:0] cnt_q;
    logic          active_q;
    logic          tick;

    assign tick   = (pre_q == PRE_LAST);
    assign done_o = active_q && tick && (cnt_q <= CNT_ONE);

    // Prescaler and microsecond down-counter; a load restarts both.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q    <= '0;
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else if (load_i) begin
            pre_q    <= '0;
            cnt_q    <= value_i;
            active_q <= 1'b1;
        end else if (active_q) begin
            if (tick) begin
                pre_q <= '0;
                cnt_q <= cnt_q - CNT_ONE;
                if (cnt_q <= CNT_ONE) active_q <= 1'b0;
            end else begin
                pre_q <= pre_q + PW'(1);
            end
        end
    end

endmodule

// File: rtl/stim_pulse_scheduler.sv
// Biphasic charge-balanced pulse sequencer driving the HS/LS switch matrix and
// current DAC. Config is shadowed at each period boundary; magnitude ramp and
// cathode sweep advance once per completed pulse.
module stim_pulse_scheduler
    import stim_pkg::*;
#(
    parameter int CLK_PER_US = 10,
    parameter int TW         = TW_DEF,
    parameter int NCH        = NCH_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           run,
    input  logic [TW-1:0]  cfg_period_us,
    input  logic [TW-1:0]  cfg_ano_us,
    input  logic [TW-1:0]  cfg_cat_us,
    input  logic [TW-1:0]  cfg_ipd_us,
    input  logic [7:0]     cfg_ext_us,
    input  logic [4:0]     cfg_mag,
    input  logic           cfg_ramp,
    input  logic           cfg_sweep,
    input  logic [NCH-1:0] cfg_ch_ano,
    input  logic [NCH-1:0] cfg_cat_mask,
    output logic           en_st,
    output logic [4:0]     mag_st,
    output logic [NCH-1:0] chsel_hs,
    output logic [NCH-1:0] chsel_ls,
    output logic           busy,
    output logic           pulse_done,
    output logic           cfg_err
);

    state_e          state_q, state_d;
    logic            en_q, en_d;
    logic [4:0]      mag_q, mag_d;
    logic [NCH-1:0]  hs_q, hs_d, ls_q, ls_d;
    logic            busy_q, pulse_done_q, cfg_err_q;
    logic [NCH-1:0]  cat_ptr_q, cat_next;
    logic [4:0]      mag_cur_q, mag_next;

    logic [TW-1:0]   ano_sh, cat_sh, ipd_sh, ext_sh;
    logic [NCH-1:0]  ch_ano_sh;

    logic signed [TW+1:0] live_rest;
    logic [TW-1:0]   rest_val;
    logic [NCH-1:0]  live_allowed;
    logic            live_ok;
    logic            start;

    logic            tmr_load, tmr_done;
    logic [TW-1:0]   tmr_val;
    logic            latch, reject, done_pulse;

    // Rest width of the live config; everything else in the period is fixed phases.
    assign live_rest = $signed({2'b00, cfg_period_us})
                     - $signed({2'b00, cfg_ano_us})
                     - $signed({2'b00, cfg_cat_us})
                     - $signed({2'b00, cfg_ipd_us})
                     - $signed({{(TW-7){1'b0}}, cfg_ext_us, 1'b0});
    assign rest_val     = live_rest[TW-1:0];
    assign live_allowed = cfg_cat_mask & ~cfg_ch_ano;
    assign live_ok      = !live_rest[TW+1] && (live_rest != '0)
                       && (cfg_ano_us != '0) && (cfg_cat_us != '0)
                       && (live_allowed != '0);
    assign start        = (state_q == IDLE);

    // Pointer and magnitude for the period about to begin (used only on latch).
    assign cat_next = (start || !cfg_sweep) ? lowest_bit(live_allowed)
                                            : next_cat(cat_ptr_q, live_allowed);
    assign mag_next = !cfg_ramp ? cfg_mag
                    : start     ? 5'd0
                    : (mag_cur_q < cfg_mag) ? mag_cur_q + 5'd1 : cfg_mag;

    stim_us_timer #(
        .CLK_PER_US (CLK_PER_US),
        .TW         (TW)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (tmr_load),
        .value_i (tmr_val),
        .done_o  (tmr_done)
    );

    // Next state, timer reload for the state being entered, and period-boundary events.
    always_comb begin
        state_d    = state_q;
        tmr_load   = 1'b0;
        tmr_val    = '0;
        latch      = 1'b0;
        reject     = 1'b0;
        done_pulse = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (run) begin
                    if (live_ok) begin
                        state_d  = REST;
                        tmr_load = 1'b1;
                        tmr_val  = rest_val;
                        latch    = 1'b1;
                    end else begin
                        reject = 1'b1;
                    end
                end
            end
            REST: begin
                if (!run) begin
                    state_d = IDLE;
                end else if (tmr_done) begin
                    state_d  = PRE;
                    tmr_load = 1'b1;
                    tmr_val  = ext_sh;
                end
            end
            PRE: begin
                if (tmr_done) begin
                    state_d  = ANO;
                    tmr_load = 1'b1;
                    tmr_val  = ano_sh;
                end
            end
            ANO: begin
                if (tmr_done) begin
                    tmr_load = 1'b1;
                    if (ipd_sh != '0) begin
                        state_d = IPD;
                        tmr_val = ipd_sh;
                    end else begin
                        state_d = CAT;
                        tmr_val = cat_sh;
                    end
                end
            end
            IPD: begin
                if (tmr_done) begin
                    state_d  = CAT;
                    tmr_load = 1'b1;
                    tmr_val  = cat_sh;
                end
            end
            CAT: begin
                if (tmr_done) begin
                    state_d  = POST;
                    tmr_load = 1'b1;
                    tmr_val  = ext_sh;
                end
            end
            POST: begin
                if (tmr_done) begin
                    done_pulse = 1'b1;
                    if (run && live_ok) begin
                        state_d  = REST;
                        tmr_load = 1'b1;
                        tmr_val  = rest_val;
                        latch    = 1'b1;
                    end else begin
                        state_d = IDLE;
                        reject  = run;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output values for the state being entered, so they land in its first cycle.
    always_comb begin
        en_d  = (state_d != IDLE) && (state_d != REST);
        mag_d = (state_d == IDLE) ? 5'd0 : (latch ? mag_next : mag_cur_q);
        hs_d  = '0;
        ls_d  = '0;
        if (state_d == ANO) begin
            hs_d = ch_ano_sh;
            ls_d = cat_ptr_q;
        end else if (state_d == CAT) begin
            hs_d = cat_ptr_q;
            ls_d = ch_ano_sh;
        end
    end

    // Shadow config captured only at period boundaries.
    always_ff @(posedge clk) begin
        if (latch) begin
            ano_sh    <= cfg_ano_us;
            cat_sh    <= cfg_cat_us;
            ipd_sh    <= cfg_ipd_us;
            ext_sh    <= TW'(cfg_ext_us);
            ch_ano_sh <= cfg_ch_ano;
        end
    end

    // FSM state, registered outputs, ramp/sweep state and sticky config error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            en_q         <= 1'b0;
            mag_q        <= '0;
            hs_q         <= '0;
            ls_q         <= '0;
            busy_q       <= 1'b0;
            pulse_done_q <= 1'b0;
            cfg_err_q    <= 1'b0;
            cat_ptr_q    <= '0;
            mag_cur_q    <= '0;
        end else begin
            state_q      <= state_d;
            en_q         <= en_d;
            mag_q        <= mag_d;
            hs_q         <= hs_d;
            ls_q         <= ls_d;
            busy_q       <= (state_d != IDLE);
            pulse_done_q <= done_pulse;
            if (latch) begin
                cat_ptr_q <= cat_next;
                mag_cur_q <= mag_next;
                cfg_err_q <= 1'b0;
            end else if (reject) begin
                cfg_err_q <= 1'b1;
            end
        end
    end

    assign en_st      = en_q;
    assign mag_st     = mag_q;
    assign chsel_hs   = hs_q;
    assign chsel_ls   = ls_q;
    assign busy       = busy_q;
    assign pulse_done = pulse_done_q;
    assign cfg_err    = cfg_err_q;

    // A channel must never be tied to both rails at once.
    a_no_shoot_through: assert property (@(posedge clk) disable iff (!rst_n)
                                         (chsel_hs & chsel_ls) == '0);

endmodule

// File: tb/tb_stim_pulse_scheduler.sv
// Directed bench: stimulus pushes one expected pulse record per pulse; a monitor
// measures each pulse from the outputs and compares on pulse_done.
module tb_stim_pulse_scheduler;

    localparam int W_EN   = 0;
    localparam int W_DONE = 1;
    localparam int W_HS   = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run;
    logic [15:0] cfg_period_us, cfg_ano_us, cfg_cat_us, cfg_ipd_us;
    logic [7:0]  cfg_ext_us;
    logic [4:0]  cfg_mag;
    logic        cfg_ramp, cfg_sweep;
    logic [3:0]  cfg_ch_ano, cfg_cat_mask;
    logic        en_st;
    logic [4:0]  mag_st;
    logic [3:0]  chsel_hs, chsel_ls;
    logic        busy, pulse_done, cfg_err;

    typedef struct {
        logic [3:0] hs_a;
        logic [3:0] ls_a;
        int         len_a;
        int         gap;
        int         len_c;
        int         pre;
        int         post;
        int         mag;
        int         per;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   pulses_seen = 0;

    stim_pulse_scheduler dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .run           (run),
        .cfg_period_us (cfg_period_us),
        .cfg_ano_us    (cfg_ano_us),
        .cfg_cat_us    (cfg_cat_us),
        .cfg_ipd_us    (cfg_ipd_us),
        .cfg_ext_us    (cfg_ext_us),
        .cfg_mag       (cfg_mag),
        .cfg_ramp      (cfg_ramp),
        .cfg_sweep     (cfg_sweep),
        .cfg_ch_ano    (cfg_ch_ano),
        .cfg_cat_mask  (cfg_cat_mask),
        .en_st         (en_st),
        .mag_st        (mag_st),
        .chsel_hs      (chsel_hs),
        .chsel_ls      (chsel_ls),
        .busy          (busy),
        .pulse_done    (pulse_done),
        .cfg_err       (cfg_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, req, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input int per, input int ano, input int cat, input int ipd,
                           input int ext, input int mag, input bit ramp, input bit sweep,
                           input logic [3:0] chano, input logic [3:0] mask);
        cfg_period_us = 16'(per);
        cfg_ano_us    = 16'(ano);
        cfg_cat_us    = 16'(cat);
        cfg_ipd_us    = 16'(ipd);
        cfg_ext_us    = 8'(ext);
        cfg_mag       = 5'(mag);
        cfg_ramp      = ramp;
        cfg_sweep     = sweep;
        cfg_ch_ano    = chano;
        cfg_cat_mask  = mask;
    endtask

    task automatic push_exp(input logic [3:0] hs_a, input logic [3:0] ls_a, input int len_a,
                            input int gap, input int len_c, input int pre, input int post,
                            input int mag, input int per);
        exp_t e;
        e.hs_a = hs_a; e.ls_a = ls_a; e.len_a = len_a; e.gap = gap; e.len_c = len_c;
        e.pre = pre; e.post = post; e.mag = mag; e.per = per;
        q.push_back(e);
    endtask

    task automatic wait_until(input int which, input logic [3:0] val, input int limit,
                              output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(posedge clk);
            #1;
            case (which)
                W_EN:    ok = en_st;
                W_DONE:  ok = pulse_done;
                default: ok = (chsel_hs == val);
            endcase
            if (ok) break;
        end
        if (!ok) check($sformatf("timeout_wait_%0d", which), 0, 1);
    endtask

    // Run n pulses; run drops on the last pulse at PRE (drop_ano=0) or in ANO (drop_ano=1).
    task automatic run_pulses(input int n, input bit drop_ano, input logic [3:0] ano);
        bit ok;
        int extra;
        run = 1'b1;
        for (int k = 0; k < n; k++) begin
            wait_until(W_EN, 4'b0, 20000, ok);
            if (k == n - 1) begin
                if (drop_ano) wait_until(W_HS, ano, 20000, ok);
                run = 1'b0;
            end
            wait_until(W_DONE, 4'b0, 20000, ok);
        end
        extra = 0;
        for (int i = 0; i < 30; i++) begin
            tick(1);
            if (pulse_done) extra++;
        end
        check("extra_pulse_done", extra, 0);
        check("idle_busy", busy, 0);
        check("idle_en", en_st, 0);
        check("idle_mag", mag_st, 0);
        check("idle_sw", {chsel_hs, chsel_ls}, 0);
    endtask

    // Monitor: measure each pulse and compare against the queued expectation.
    initial begin
        int         ph, since, m_en, m_pre, m_len_a, m_gap, m_len_c, m_post, m_mag;
        logic [3:0] m_hs_a, m_ls_a, m_hs_c, m_ls_c;
        exp_t       e;
        ph = 0; since = 0; m_en = 0; m_pre = 0; m_len_a = 0; m_gap = 0;
        m_len_c = 0; m_post = 0; m_mag = 0;
        m_hs_a = '0; m_ls_a = '0; m_hs_c = '0; m_ls_c = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                ph = 0; since = 0; m_en = 0; m_pre = 0; m_len_a = 0; m_gap = 0;
                m_len_c = 0; m_post = 0;
            end else begin
                since++;
                if (en_st) m_en++;
                case (ph)
                    0: if (chsel_hs != 0) begin
                           ph = 1; m_hs_a = chsel_hs; m_ls_a = chsel_ls;
                           m_mag = int'(mag_st); m_len_a = 1;
                       end else if (en_st) m_pre++;
                    1: if (chsel_hs == m_hs_a) m_len_a++;
                       else if (chsel_hs != 0) begin
                           ph = 3; m_hs_c = chsel_hs; m_ls_c = chsel_ls; m_len_c = 1;
                       end else begin
                           ph = 2; m_gap = 1;
                       end
                    2: if (chsel_hs != 0) begin
                           ph = 3; m_hs_c = chsel_hs; m_ls_c = chsel_ls; m_len_c = 1;
                       end else m_gap++;
                    3: if (chsel_hs != 0) m_len_c++;
                       else begin
                           ph = 4; if (en_st) m_post = 1;
                       end
                    default: if (en_st) m_post++;
                endcase
                if (pulse_done) begin
                    pulses_seen++;
                    if (q.size() == 0) begin
                        check("unexpected_pulse", 1, 0);
                    end else begin
                        e = q.pop_front();
                        check("ano_hs", m_hs_a, e.hs_a);
                        check("ano_ls", m_ls_a, e.ls_a);
                        check("ano_len", m_len_a, e.len_a);
                        check("ipd_gap", m_gap, e.gap);
                        check("cat_hs", m_hs_c, e.ls_a);
                        check("cat_ls", m_ls_c, e.hs_a);
                        check("cat_len", m_len_c, e.len_c);
                        check("pre_len", m_pre, e.pre);
                        check("post_len", m_post, e.post);
                        check("en_len", m_en, e.pre + e.len_a + e.gap + e.len_c + e.post);
                        check("mag", m_mag, e.mag);
                        if (e.per != 0) check("period", since, e.per);
                    end
                    ph = 0; since = 0; m_en = 0; m_pre = 0; m_len_a = 0; m_gap = 0;
                    m_len_c = 0; m_post = 0;
                end
            end
        end
    end

    // Stimulus
    initial begin
        rst_n = 1'b0;
        run   = 1'b0;
        set_cfg(500, 150, 150, 10, 10, 31, 0, 0, 4'b0001, 4'b0010);
        tick(5);
        check("rst_en", en_st, 0);
        check("rst_mag", mag_st, 0);
        check("rst_sw", {chsel_hs, chsel_ls}, 0);
        check("rst_busy", busy, 0);
        check("rst_flags", {pulse_done, cfg_err}, 0);
        rst_n = 1'b1;
        tick(2);

        // Default waveform: 330 us enable, 150/10/150 us phases, 5000-cycle period.
        push_exp(4'b0001, 4'b0010, 1500, 100, 1500, 100, 100, 31, 0);
        push_exp(4'b0001, 4'b0010, 1500, 100, 1500, 100, 100, 31, 5000);
        run_pulses(2, 1'b0, 4'b0001);

        // Period too short for the phases: rejected, nothing moves.
        set_cfg(300, 150, 150, 10, 10, 31, 0, 0, 4'b0001, 4'b0010);
        run = 1'b1;
        tick(4);
        check("err_set", cfg_err, 1);
        check("err_busy", busy, 0);
        check("err_out", {en_st, chsel_hs, chsel_ls, mag_st}, 0);
        run = 1'b0;
        tick(1);

        // Valid start clears the error; run dropped in REST returns to IDLE next cycle.
        set_cfg(50, 10, 10, 5, 2, 7, 0, 0, 4'b0001, 4'b0010);
        run = 1'b1;
        tick(1);
        check("err_clear", cfg_err, 0);
        check("start_busy", busy, 1);
        tick(3);
        run = 1'b0;
        tick(1);
        check("rest_drop_busy", busy, 0);
        check("rest_drop_mag", mag_st, 0);
        tick(2);

        // Magnitude ramp 0,1,2,3,3.
        set_cfg(50, 10, 10, 5, 2, 3, 1, 0, 4'b0001, 4'b0010);
        push_exp(4'b0001, 4'b0010, 100, 50, 100, 20, 20, 0, 0);
        push_exp(4'b0001, 4'b0010, 100, 50, 100, 20, 20, 1, 500);
        push_exp(4'b0001, 4'b0010, 100, 50, 100, 20, 20, 2, 500);
        push_exp(4'b0001, 4'b0010, 100, 50, 100, 20, 20, 3, 500);
        push_exp(4'b0001, 4'b0010, 100, 50, 100, 20, 20, 3, 500);
        run_pulses(5, 1'b0, 4'b0001);

        // Cathode sweep over 1110 with anode 0001; last pulse has run dropped mid-ANO.
        set_cfg(50, 10, 10, 5, 2, 5, 0, 1, 4'b0001, 4'b1110);
        push_exp(4'b0001, 4'b0010, 100, 50, 100, 20, 20, 5, 0);
        push_exp(4'b0001, 4'b0100, 100, 50, 100, 20, 20, 5, 500);
        push_exp(4'b0001, 4'b1000, 100, 50, 100, 20, 20, 5, 500);
        push_exp(4'b0001, 4'b0010, 100, 50, 100, 20, 20, 5, 500);
        run_pulses(4, 1'b1, 4'b0001);

        // Sweep with a single allowed cathode, zero inter-pulse delay.
        set_cfg(50, 10, 10, 0, 2, 9, 0, 1, 4'b0001, 4'b0011);
        push_exp(4'b0001, 4'b0010, 100, 0, 100, 20, 20, 9, 0);
        push_exp(4'b0001, 4'b0010, 100, 0, 100, 20, 20, 9, 500);
        run_pulses(2, 1'b1, 4'b0001);

        // Asynchronous reset in the middle of the cathodic phase.
        begin
            bit ok;
            set_cfg(50, 10, 10, 5, 2, 6, 0, 0, 4'b0001, 4'b0010);
            run = 1'b1;
            wait_until(W_HS, 4'b0010, 20000, ok);
            tick(5);
            check("mid_cat_hs", chsel_hs, 4'b0010);
            #2;
            rst_n = 1'b0;
            #1;
            check("async_rst_en", en_st, 0);
            check("async_rst_sw", {chsel_hs, chsel_ls}, 0);
            check("async_rst_busy", busy, 0);
            run = 1'b0;
            tick(2);
            rst_n = 1'b1;
            tick(10);
            check("post_rst_idle", {busy, en_st, mag_st, chsel_hs, chsel_ls}, 0);
            run = 1'b1;
            tick(1);
            check("post_rst_start", busy, 1);
            run = 1'b0;
            tick(1);
            check("post_rst_stop", busy, 0);
        end

        tick(5);
        check("exp_queue_drained", q.size(), 0);
        check("pulses_seen", pulses_seen, 13);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/stim_pulse_scheduler.md
Name: stim_pulse_scheduler

Overview:
- Synthesizable, clocked sequencer for the stimulator front-end: drives the same stimulus bus as the behavioural stimulus model (en_st, mag_st, chsel_hs, chsel_ls).
- Generates periodic charge-balanced biphasic pulses: anodic phase, inter-pulse delay, cathodic phase, with enable guard bands around the pulse.
- Supports magnitude ramping and cathode-channel sweeping.
- Sits between the configuration register bank and the HS/LS switch matrix plus current DAC.

Parameters:
- CLK_PER_US, 10, clock cycles per microsecond (integer, ≥2)
- TW, 16, width of the microsecond timing fields
- NCH, 4, number of electrode channels (fixed 4 in this revision)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- run  in  1  level; 1 = stimulate, 0 = stop gracefully
- cfg_period_us  in  TW  stimulus period
- cfg_ano_us  in  TW  anodic phase width
- cfg_cat_us  in  TW  cathodic phase width
- cfg_ipd_us  in  TW  inter-pulse delay (0 allowed)
- cfg_ext_us  in  8  enable guard band before and after the pulse
- cfg_mag  in  5  target magnitude code
- cfg_ramp  in  1  ramp mag_st from 0 to cfg_mag
- cfg_sweep  in  1  rotate cathode through cfg_cat_mask
- cfg_ch_ano  in  4  one-hot anode channel
- cfg_cat_mask  in  4  set of allowed cathode channels
- en_st  out  1  stimulator enable
- mag_st  out  5  DAC magnitude
- chsel_hs  out  4  high-side switch select
- chsel_ls  out  4  low-side switch select
- busy  out  1  state != IDLE
- pulse_done  out  1  1-cycle strobe at the end of POST
- cfg_err  out  1  sticky until next accepted start; config rejected

Behaviour:
- Reset (async, rst_n=0): state IDLE; en_st=0, mag_st=0, chsel_hs=0, chsel_ls=0, busy=0, pulse_done=0, cfg_err=0. Timers and cathode pointer cleared.
- All outputs are registered and take their new value in the first cycle of the new state.
- States: IDLE → REST → PRE → ANO → IPD → CAT → POST → REST …
- Timer: sub-module prescaler ticks every CLK_PER_US cycles. Each state lasts exactly N×CLK_PER_US cycles, where N is its µs width.
  - REST width = period − ano − cat − ipd − 2·ext.
  - PRE and POST widths = ext.
  - IPD with width 0 is skipped (ANO→CAT directly).
- IDLE→REST on run=1: config is latched into shadow registers, and the rest width is computed at TW+2 bits signed. If rest ≤ 0, or ano=0, or cat=0, or cfg_cat_mask & ~cfg_ch_ano == 0, the block sets cfg_err=1 and stays IDLE. A valid start clears cfg_err.
- Outputs per state, as (hs, ls, en):
  - REST: (0, 0, 0)
  - PRE: (0, 0, 1)
  - ANO: (ano, cat, 1)
  - IPD: (0, 0, 1)
  - CAT: (cat, ano, 1)
  - POST: (0, 0, 1)
- At the end of POST: pulse_done=1 for one cycle, en_st=0, and config is re-latched for the next period.
- Shadow config: live cfg_* changes take effect only at a period boundary (IDLE→REST or POST→REST).
- Cathode pointer:
  - Initial cathode = lowest set bit of (cfg_cat_mask & ~cfg_ch_ano).
  - With cfg_sweep=1, after each POST the pointer advances to the next higher allowed bit, wrapping to the lowest.
  - With cfg_sweep=0 it stays fixed.
- Magnitude:
  - cfg_ramp=0: mag_st = latched cfg_mag from REST entry.
  - cfg_ramp=1: mag_st = 0 at start and increments by 1 after each POST, saturating at cfg_mag. No wrap past 31.
- run=0 while in REST or IDLE: go to IDLE next cycle, with all outputs 0.
- run=0 during PRE..POST: the current pulse completes fully (charge balance), then IDLE. pulse_done still fires.
- Reset mid-pulse: all switches open immediately (async); no partial phase is resumed.
- run=1 re-assertion in the same cycle as POST end: continues to REST (no IDLE detour).
- chsel_hs & chsel_ls is always 0 (invariant; covered by an assertion).

Decomposition:
- Package stim_pkg:
  - state enum (IDLE, REST, PRE, ANO, IPD, CAT, POST)
  - TW default, NCH
  - function next_cat(ptr, mask) → next allowed one-hot bit with wrap
- Sub-module stim_us_timer: prescaler plus TW-bit down-counter, with load/value inputs and a done strobe.
- The FSM, shadow registers, ramp and sweep logic live in stim_pulse_scheduler.

Test Plan:
- Defaults: CLK_PER_US=10, period=500, ano=cat=150, ipd=10, ext=10, mag=31, ano=0001, mask=0010; run=1 → en_st high for 330 µs (3300 cycles) per 5000-cycle period; hs=0001/ls=0010 for 1500 cycles, then 100 cycles open, then hs=0010/ls=0001 for 1500 cycles.
- period=300 with the same phases → cfg_err=1, busy=0, outputs stay 0.
- cfg_ramp=1, mag=3 → mag_st = 0, 1, 2, 3, 3 over five consecutive pulses.
- cfg_sweep=1, mask=1110, ano=0001 → cathode sequence 0010, 0100, 1000, 0010; mask=0011 with ano=0001 → cathode fixed at 0010.
- run dropped mid-ANO → CAT and POST complete, pulse_done fires once, then IDLE with all outputs 0; run dropped in REST → IDLE next cycle.
- rst_n asserted mid-CAT → outputs 0 asynchronously, before the next clk edge; after release the block sits in IDLE until run.
